// File: rtl/sha256_stream_padder.sv
// ---------------------------------------------------------------------------
// sha256_stream_padder
//
// Purpose:
//    AXI-Stream stage between the DMA MM2S channel and the SHA-256 core's
//    32-bit stream input. Raw message bytes go in. The fully padded message
//    comes out:
//       - the message words are forwarded,
//       - a 0x80 marker byte follows the last message byte,
//       - zero words fill the block,
//       - the 64-bit big-endian bit length closes the block.
//    The output is always a whole number of 512-bit blocks. tlast marks
//    word 15 of the final block.
//
// Byte order:
//    On both streams, byte k of a beat sits in tdata[8k+7:8k]. Byte 0 is the
//    earliest byte of the message.
//
// Ports:
//    aclk           single clock for both streams
//    aresetn        asynchronous active-low reset; a partial message is dropped
//    s_axis_tdata   message bytes
//    s_axis_tkeep   valid bytes; only honoured on the tlast beat, contiguous from bit 0
//    s_axis_tlast   last beat of the message
//    s_axis_tvalid  input beat valid
//    s_axis_tready  input beat accepted
//    m_axis_tdata   padded message word
//    m_axis_tlast   last word of the padded message
//    m_axis_tvalid  output word valid
//    m_axis_tready  downstream core ready
//    busy           high from the first accepted beat until the final word is taken
//    msg_done       one-cycle pulse while the final output word handshakes
// ---------------------------------------------------------------------------
module sha256_stream_padder #(
   parameter int BYTE_CNT_W = 61
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] s_axis_tdata,
   input  logic [3:0]  s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        busy,
   output logic        msg_done
);

   // Phases of producing one padded message.
   // PASS forwards message beats. MARK emits the lone marker word after a
   // full final beat. ZERO fills the block. LENH and LENL emit the length.
   typedef enum logic [2:0] {
      PASS,
      MARK,
      ZERO,
      LENH,
      LENL
   } state_e;

   state_e                  state_q, state_d;
   logic [31:0]             tdata_q, tdata_d;
   logic                    tlast_q, tlast_d;
   logic                    tvalid_q, tvalid_d;
   logic [3:0]              widx_q, widx_d;
   logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
   logic                    busy_q, busy_d;

   logic                    outLoad;
   logic                    inReady;
   logic                    inHandshake;
   logic                    finalHandshake;
   logic [3:0]              widxNext;
   logic [2:0]              beatBytes;
   logic [63:0]             lenBits;

   // The output register takes a new word whenever it is empty or its
   // current word is being consumed in this cycle. Input is only accepted
   // while forwarding, so padding words never compete with message beats.
   always_comb begin
      outLoad        = !tvalid_q || m_axis_tready;
      inReady        = (state_q == PASS) && outLoad;
      inHandshake    = inReady && s_axis_tvalid;
      finalHandshake = tvalid_q && tlast_q && m_axis_tready;
      widxNext       = widx_q + 4'd1;
      lenBits        = 64'({cnt_q, 3'b000});
   end

   // Bytes contributed by the accepted beat. Only the tlast beat may be
   // partial, and its keep mask is contiguous from bit 0.
   always_comb begin
      beatBytes = 3'd4;
      if (s_axis_tlast) begin
         casez (s_axis_tkeep)
            4'b1???: beatBytes = 3'd4;
            4'b01??: beatBytes = 3'd3;
            4'b001?: beatBytes = 3'd2;
            4'b0001: beatBytes = 3'd1;
            default: beatBytes = 3'd0;
         endcase
      end
   end

   // Next-state and output-word selection. Every branch that loads the
   // output register advances the word index. The padding states then count
   // that index up to 14. Words 14 and 15 of a block always carry the
   // length. A marker that lands on word 14 or 15 therefore wraps through a
   // whole extra block of zeros before the length is emitted.
   always_comb begin
      state_d  = state_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q;
      widx_d   = widx_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;

      if (outLoad) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end

      unique case (state_q)
         PASS: begin
            if (inHandshake) begin
               tvalid_d = 1'b1;
               widx_d   = widxNext;
               cnt_d    = cnt_q + BYTE_CNT_W'(beatBytes);
               tdata_d  = s_axis_tdata;
               if (s_axis_tlast) begin
                  if (beatBytes == 3'd4) begin
                     state_d = MARK;
                  end else begin
                     unique case (beatBytes)
                        3'd3:    tdata_d = {8'h80, s_axis_tdata[23:0]};
                        3'd2:    tdata_d = {8'h00, 8'h80, s_axis_tdata[15:0]};
                        3'd1:    tdata_d = {16'h0000, 8'h80, s_axis_tdata[7:0]};
                        default: tdata_d = 32'h0000_0080;
                     endcase
                     state_d = (widxNext == 4'd14) ? LENH : ZERO;
                  end
               end
            end
         end

         MARK: begin
            if (outLoad) begin
               tvalid_d = 1'b1;
               tdata_d  = 32'h0000_0080;
               widx_d   = widxNext;
               state_d  = (widxNext == 4'd14) ? LENH : ZERO;
            end
         end

         ZERO: begin
            if (outLoad) begin
               tvalid_d = 1'b1;
               tdata_d  = 32'h0000_0000;
               widx_d   = widxNext;
               if (widxNext == 4'd14) begin
                  state_d = LENH;
               end
            end
         end

         LENH: begin
            if (outLoad) begin
               tvalid_d = 1'b1;
               tdata_d  = {lenBits[39:32], lenBits[47:40], lenBits[55:48], lenBits[63:56]};
               widx_d   = widxNext;
               state_d  = LENL;
            end
         end

         LENL: begin
            if (outLoad) begin
               tvalid_d = 1'b1;
               tlast_d  = 1'b1;
               tdata_d  = {lenBits[7:0], lenBits[15:8], lenBits[23:16], lenBits[31:24]};
               widx_d   = widxNext;
               cnt_d    = '0;
               state_d  = PASS;
            end
         end

         default: begin
            state_d = PASS;
         end
      endcase

      // A new message can start in the same cycle that the previous one's
      // final word leaves. The set therefore has priority over the clear.
      if (inHandshake) begin
         busy_d = 1'b1;
      end else if (finalHandshake) begin
         busy_d = 1'b0;
      end
   end

   // State and output registers. An asynchronous reset abandons any message
   // in flight and empties the output stage immediately.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= PASS;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         widx_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         tvalid_q <= tvalid_d;
         widx_q   <= widx_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   // Output port mapping.
   always_comb begin
      s_axis_tready = inReady;
      m_axis_tdata  = tdata_q;
      m_axis_tlast  = tlast_q;
      m_axis_tvalid = tvalid_q;
      busy          = busy_q;
      msg_done      = finalHandshake;
   end

endmodule
